btn_updown_counter: RTL

- Parametrised up/down counter driven by two raw push-buttons; successor to the lab1 LED counter.
- Adds button synchronisation, debounce, single-step-per-press edge detection, hold-to-auto-repeat, programmable modulus, wrap/saturate mode, parallel load and overflow/underflow status.
- Sits between the board buttons and the LED/7-seg drivers, clocked by the divided clock clk_out.

---
 rtl/btn_updown_counter_pkg.sv | 9 +
 rtl/btn_updown_counter_if.sv | 13 +
 rtl/btn_updown_counter_conditioner.sv | 75 +++++++
 rtl/btn_updown_counter.sv | 45 ++++
 4 files changed

// File: rtl/btn_updown_counter_pkg.sv
// btn_counter_pkg: shared conditioner state encoding and counter sizing helper
package btn_counter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} cond_state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction
endpackage

// File: rtl/btn_updown_counter_if.sv
// btn_updown_counter_if: counter bus; master drives load/load_val/wrap_en, slave returns count/at_max/at_min/ovf_pulse/unf_pulse
interface btn_updown_counter_if #(parameter int WIDTH = 4);
  logic load;
  logic [WIDTH-1:0] load_val;
  logic wrap_en;
  logic [WIDTH-1:0] count;
  logic at_max;
  logic at_min;
  logic ovf_pulse;
  logic unf_pulse;
  modport master(output load, load_val, wrap_en, input count, at_max, at_min, ovf_pulse, unf_pulse);
  modport slave(input load, load_val, wrap_en, output count, at_max, at_min, ovf_pulse, unf_pulse);
endinterface

// File: rtl/btn_updown_counter_conditioner.sv
// btn_conditioner: raw button -> 2-flop sync, debounce, press/hold/auto-repeat step pulse (ports: clk_out, rst, btn in; step out)
module btn_conditioner
  import btn_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk_out,
  input  logic rst,
  input  logic btn,
  output logic step
);
  localparam int DW = clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [1:0] sync;
  logic deb;
  logic [DW-1:0] dcnt;
  cond_state_t state, state_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic step_nx;
  always_ff @(posedge clk_out) begin
    if (rst) begin
      sync <= '0;
      deb  <= 1'b0;
      dcnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == deb) dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb  <= ~deb;
        dcnt <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  end
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      step  <= step_nx;
    end
  end
  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt + 1'b1;
    step_nx  = 1'b0;
    case (state)
      IDLE: begin
        rcnt_nx = '0;
        if (deb) begin
          state_nx = HOLD;
          step_nx  = 1'b1;
        end
      end
      HOLD:
        if (!deb) state_nx = IDLE;
        else if (REPEAT_DELAY != 0 && rcnt == RW'(REPEAT_DELAY - 1)) begin
          state_nx = REPEAT;
          step_nx  = 1'b1;
          rcnt_nx  = '0;
        end
      REPEAT:
        if (!deb) state_nx = IDLE;
        else if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
          step_nx = 1'b1;
          rcnt_nx = '0;
        end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: rtl/btn_updown_counter.sv
// btn_updown_counter: button-driven up/down counter with load, wrap/saturate, ovf/unf pulses (ports: clk_out, rst, btn_up, btn_dn, bus slave)
module btn_updown_counter
  import btn_counter_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MAX_VAL         = 2 ** WIDTH - 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk_out,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  btn_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic up, dn, ovf_nx, unf_nx;
  logic [WIDTH-1:0] count_nx;
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_up (.clk_out(clk_out), .rst(rst), .btn(btn_up), .step(up));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_dn (.clk_out(clk_out), .rst(rst), .btn(btn_dn), .step(dn));
  always_comb begin
    ovf_nx   = !bus.load && up && !dn && bus.count == MAX;
    unf_nx   = !bus.load && dn && !up && bus.count == '0;
    count_nx = bus.load ? (bus.load_val > MAX ? MAX : bus.load_val)
             : (up && !dn) ? (bus.count == MAX ? (bus.wrap_en ? '0 : MAX) : bus.count + 1'b1)
             : (dn && !up) ? (bus.count == '0 ? (bus.wrap_en ? MAX : '0) : bus.count - 1'b1)
             : bus.count;
  end
  always_ff @(posedge clk_out) begin
    if (rst) begin
      bus.count     <= '0;
      bus.ovf_pulse <= 1'b0;
      bus.unf_pulse <= 1'b0;
    end else begin
      bus.count     <= count_nx;
      bus.ovf_pulse <= ovf_nx;
      bus.unf_pulse <= unf_nx;
    end
  end
  assign bus.at_max = bus.count == MAX;
  assign bus.at_min = bus.count == '0;
endmodule
